video_format_detector: RTL and testbench

//  Measures incoming hsync/vsync timing on clk_50mhz_in and classifies it as no signal, 576i50, 480i60, 576p50 or 480p60.

---
 rtl/video_format_detector.sv | 184 ++++++++++++++++++
 tb/tb_video_format_detector.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/video_format_detector.sv
// Measures hsync/vsync timing, classifies the SD video format and publishes a debounced
// format code with a one-clock change strobe.
module video_format_detector #(
    parameter int unsigned STABLE_FIELDS = 4,
    parameter int unsigned HS_TIMEOUT    = 8192,
    parameter int unsigned VS_TIMEOUT    = 2500000
) (
    input  logic        clk_50mhz_in,
    input  logic        reset_x,
    input  logic        hsync_in,
    input  logic        vsync_in,
    input  logic        hs_active_low,
    input  logic        vs_active_low,
    output logic [7:0]  video_format,
    output logic        format_valid,
    output logic        format_change,
    output logic [11:0] line_period,
    output logic [9:0]  field_lines
);

    // Wide enough that the timeout value itself is reachable.
    localparam int unsigned HtW = $clog2(HS_TIMEOUT + 1);
    localparam int unsigned VtW = $clog2(VS_TIMEOUT + 1);
    localparam logic [HtW-1:0] HsMax = HtW'(HS_TIMEOUT);
    localparam logic [VtW-1:0] VsMax = VtW'(VS_TIMEOUT);
    localparam logic [HtW-1:0] LpMax = HtW'(4095);
    localparam logic [2:0] StableCnt = 3'(STABLE_FIELDS);

    typedef enum logic [1:0] {StNoSig, StAcquire, StLocked} state_e;

    logic [1:0]     hs_sync_q, vs_sync_q;
    logic           hs_prev_q, vs_prev_q, hs_edge_q, vs_edge_q;
    logic           hs_lvl, vs_lvl;
    logic [HtW-1:0] line_timer_q;
    logic [VtW-1:0] field_timer_q;
    logic           hs_lost_q, vs_lost_q;
    logic [11:0]    line_period_q, period_new, p_cur;
    logic [9:0]     line_cnt_q, lines_inc, field_lines_q;
    logic [7:0]     field_class;
    state_e         state_q, state_d;
    logic [7:0]     cand_q, cand_d, vf_q, vf_d, vf_prev_q;
    logic [2:0]     cand_cnt_q, cand_cnt_d;
    logic           started_q, started_d, fc_q;

    function automatic logic [7:0] classify(input logic [11:0] p, input logic [9:0] l);
        logic p_slow, p_fast;
        p_slow = (p >= 12'd3100) && (p <= 12'd3300);
        p_fast = (p >= 12'd1550) && (p <= 12'd1650);
        if (p_slow && (l >= 10'd300) && (l <= 10'd325))      classify = 8'h01;
        else if (p_slow && (l >= 10'd250) && (l <= 10'd275)) classify = 8'h02;
        else if (p_fast && (l >= 10'd610) && (l <= 10'd640)) classify = 8'h03;
        else if (p_fast && (l >= 10'd510) && (l <= 10'd540)) classify = 8'h04;
        else                                                  classify = 8'h00;
    endfunction

    assign hs_lvl = hs_sync_q[1] ^ hs_active_low;
    assign vs_lvl = vs_sync_q[1] ^ vs_active_low;

    always_ff @(posedge clk_50mhz_in or negedge reset_x) begin
        if (!reset_x) begin
            hs_sync_q <= '0;
            vs_sync_q <= '0;
            // Start as if mid-pulse so reset release never looks like a sync edge.
            hs_prev_q <= 1'b1;
            vs_prev_q <= 1'b1;
            hs_edge_q <= 1'b0;
            vs_edge_q <= 1'b0;
        end else begin
            hs_sync_q <= {hs_sync_q[0], hsync_in};
            vs_sync_q <= {vs_sync_q[0], vsync_in};
            hs_prev_q <= hs_lvl;
            vs_prev_q <= vs_lvl;
            hs_edge_q <= hs_lvl & ~hs_prev_q;
            vs_edge_q <= vs_lvl & ~vs_prev_q;
        end
    end

    assign period_new  = (line_timer_q > LpMax) ? 12'hfff : line_timer_q[11:0];
    assign lines_inc   = (hs_edge_q && (line_cnt_q != 10'h3ff)) ? line_cnt_q + 10'd1 : line_cnt_q;
    // Classify the field that is closing, including a coincident hsync.
    assign p_cur       = hs_edge_q ? period_new : line_period_q;
    assign field_class = classify(p_cur, lines_inc);

    always_ff @(posedge clk_50mhz_in or negedge reset_x) begin
        if (!reset_x) begin
            line_timer_q  <= '0;
            field_timer_q <= '0;
            hs_lost_q     <= 1'b0;
            vs_lost_q     <= 1'b0;
            line_period_q <= '0;
            line_cnt_q    <= '0;
            field_lines_q <= '0;
        end else begin
            if (hs_edge_q) begin
                line_timer_q  <= HtW'(1);
                hs_lost_q     <= 1'b0;
                line_period_q <= period_new;
            end else if (line_timer_q != HsMax) begin
                line_timer_q <= line_timer_q + HtW'(1);
            end else begin
                hs_lost_q <= 1'b1;
            end

            if (vs_edge_q) begin
                field_timer_q <= VtW'(1);
                vs_lost_q     <= 1'b0;
                field_lines_q <= lines_inc;
                line_cnt_q    <= '0;
            end else begin
                line_cnt_q <= lines_inc;
                if (field_timer_q != VsMax) field_timer_q <= field_timer_q + VtW'(1);
                else                        vs_lost_q     <= 1'b1;
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        cand_d     = cand_q;
        cand_cnt_d = cand_cnt_q;
        started_d  = started_q;
        vf_d       = vf_q;
        unique case (state_q)
            StNoSig: begin
                vf_d       = 8'h00;
                cand_d     = 8'h00;
                cand_cnt_d = 3'd0;
                started_d  = 1'b0;
                if (hs_edge_q && !vs_lost_q) state_d = StAcquire;
            end
            StAcquire, StLocked: begin
                if (vs_edge_q) started_d = 1'b1;
                if (vs_edge_q && started_q && !hs_lost_q) begin
                    if (field_class == cand_q) begin
                        cand_cnt_d = (cand_cnt_q == 3'd7) ? 3'd7 : cand_cnt_q + 3'd1;
                    end else begin
                        cand_d     = field_class;
                        cand_cnt_d = 3'd1;
                    end
                end
                if (hs_lost_q || vs_lost_q) begin
                    state_d = StNoSig;
                    vf_d    = 8'h00;
                end else if (state_q == StAcquire) begin
                    if ((cand_cnt_q >= StableCnt) && (cand_q != 8'h00)) begin
                        state_d = StLocked;
                        vf_d    = cand_q;
                    end
                end else if ((cand_cnt_q >= StableCnt) && (cand_q != vf_q)) begin
                    vf_d = cand_q;
                    if (cand_q == 8'h00) state_d = StAcquire;
                end
            end
            default: state_d = StNoSig;
        endcase
    end

    always_ff @(posedge clk_50mhz_in or negedge reset_x) begin
        if (!reset_x) begin
            state_q    <= StNoSig;
            cand_q     <= '0;
            cand_cnt_q <= '0;
            started_q  <= 1'b0;
            vf_q       <= '0;
            vf_prev_q  <= '0;
            fc_q       <= 1'b0;
        end else begin
            state_q    <= state_d;
            cand_q     <= cand_d;
            cand_cnt_q <= cand_cnt_d;
            started_q  <= started_d;
            vf_q       <= vf_d;
            vf_prev_q  <= vf_q;
            fc_q       <= (vf_q != vf_prev_q);
        end
    end

    assign video_format  = vf_q;
    assign format_valid  = (state_q == StLocked);
    assign format_change = fc_q;
    assign line_period   = line_period_q;
    assign field_lines   = field_lines_q;

endmodule

// File: tb/tb_video_format_detector.sv
// Directed bench for video_format_detector: short filler lines keep fields cheap while the
// last line of each field carries the real period that drives classification.
module tb_video_format_detector;

    logic        clk_50mhz_in = 1'b0;
    logic        reset_x;
    logic        hsync_in, vsync_in, hs_active_low, vs_active_low;
    logic [7:0]  video_format;
    logic        format_valid, format_change;
    logic [11:0] line_period;
    logic [9:0]  field_lines;

    int n_checks = 0;
    int n_pass   = 0;
    int fc_count = 0;

    video_format_detector dut (
        .clk_50mhz_in  (clk_50mhz_in),
        .reset_x       (reset_x),
        .hsync_in      (hsync_in),
        .vsync_in      (vsync_in),
        .hs_active_low (hs_active_low),
        .vs_active_low (vs_active_low),
        .video_format  (video_format),
        .format_valid  (format_valid),
        .format_change (format_change),
        .line_period   (line_period),
        .field_lines   (field_lines)
    );

    always #10 clk_50mhz_in = ~clk_50mhz_in;

    always @(posedge clk_50mhz_in) begin
        if (format_change === 1'b1) fc_count <= fc_count + 1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk_50mhz_in);
        #1;
    endtask

    task automatic pulse(input bit hs, input bit vs);
        hsync_in = hs ^ hs_active_low;
        vsync_in = vs ^ vs_active_low;
        tick(1);
        hsync_in = hs_active_low;
        vsync_in = vs_active_low;
    endtask

    // nl hsync pulses 2 clk apart except the last interval (p clk), then vsync,
    // either coincident with the last hsync or 2 clk after it.
    task automatic field(input int nl, input int p, input bit coin);
        for (int i = 1; i <= nl; i++) begin
            pulse(1'b1, coin && (i == nl));
            tick((i == nl - 1) ? p - 1 : 1);
        end
        if (!coin) begin
            pulse(1'b0, 1'b1);
            tick(1);
        end
    endtask

    initial begin
        reset_x       = 1'b0;
        hs_active_low = 1'b1;
        vs_active_low = 1'b1;
        hsync_in      = 1'b1;
        vsync_in      = 1'b1;
        tick(3);
        check("rst_fmt", video_format, 8'h00);
        check("rst_valid", format_valid, 1'b0);
        check("rst_change", format_change, 1'b0);
        check("rst_period", line_period, 12'd0);
        check("rst_lines", field_lines, 10'd0);

        // No sync activity
        reset_x = 1'b1;
        tick(300);
        check("idle_fmt", video_format, 8'h00);
        check("idle_valid", format_valid, 1'b0);
        check("idle_changes", fc_count, 0);

        // 576i lock
        for (int i = 0; i < 4; i++) field(312 + (i % 2), 3200, 1'b0);
        tick(10);
        check("576i_early_valid", format_valid, 1'b0);
        check("576i_early_fmt", video_format, 8'h00);
        field(312, 3200, 1'b0);
        tick(10);
        check("576i_fmt", video_format, 8'h01);
        check("576i_valid", format_valid, 1'b1);
        check("576i_changes", fc_count, 1);
        check("576i_period", line_period, 12'd3200);
        check("576i_lines", field_lines, 10'd312);

        // 576i -> 576p while locked
        for (int i = 0; i < 3; i++) field(625, 1600, 1'b0);
        tick(10);
        check("576p_hold_fmt", video_format, 8'h01);
        check("576p_hold_changes", fc_count, 1);
        field(625, 1600, 1'b0);
        tick(10);
        check("576p_fmt", video_format, 8'h03);
        check("576p_changes", fc_count, 2);
        check("576p_period", line_period, 12'd1600);
        check("576p_lines", field_lines, 10'd625);

        // 576p -> 480p
        for (int i = 0; i < 3; i++) begin
            field(525, 1589, 1'b0);
            tick(10);
            check("480p_hold_fmt", video_format, 8'h03);
        end
        check("480p_hold_changes", fc_count, 2);
        field(525, 1589, 1'b0);
        tick(10);
        check("480p_fmt", video_format, 8'h04);
        check("480p_changes", fc_count, 3);
        check("480p_period", line_period, 12'd1589);
        check("480p_lines", field_lines, 10'd525);

        // One corrupted field inside 480p
        field(400, 1589, 1'b0);
        tick(10);
        check("bad_lines", field_lines, 10'd400);
        check("bad_fmt", video_format, 8'h04);
        field(525, 1589, 1'b0);
        tick(10);
        check("after_bad_fmt", video_format, 8'h04);
        check("after_bad_valid", format_valid, 1'b1);
        check("after_bad_changes", fc_count, 3);

        // Async reset while locked
        @(posedge clk_50mhz_in);
        #5 reset_x = 1'b0;
        #1;
        check("rstlock_fmt", video_format, 8'h00);
        check("rstlock_valid", format_valid, 1'b0);
        check("rstlock_period", line_period, 12'd0);
        check("rstlock_lines", field_lines, 10'd0);

        // Inverted polarity from here on
        hs_active_low = 1'b0;
        vs_active_low = 1'b0;
        hsync_in      = 1'b0;
        vsync_in      = 1'b0;
        tick(2);
        reset_x = 1'b1;
        field(262, 3178, 1'b0);
        tick(10);
        check("acq_period", line_period, 12'd3178);
        check("acq_lines", field_lines, 10'd262);
        check("acq_valid", format_valid, 1'b0);

        // Async reset mid-ACQUIRE
        @(posedge clk_50mhz_in);
        #5 reset_x = 1'b0;
        #1;
        check("rstacq_fmt", video_format, 8'h00);
        check("rstacq_valid", format_valid, 1'b0);
        check("rstacq_period", line_period, 12'd0);
        check("rstacq_lines", field_lines, 10'd0);
        tick(2);
        reset_x = 1'b1;

        // Relock at 480i with hsync coincident with vsync
        field(262, 3178, 1'b0);
        field(263, 3178, 1'b1);
        tick(10);
        check("coin_lines", field_lines, 10'd263);
        field(262, 3178, 1'b1);
        field(263, 3178, 1'b1);
        tick(10);
        check("relock_early_valid", format_valid, 1'b0);
        check("relock_early_fmt", video_format, 8'h00);
        field(262, 3178, 1'b1);
        tick(10);
        check("480i_fmt", video_format, 8'h02);
        check("480i_valid", format_valid, 1'b1);
        check("480i_changes", fc_count, 4);
        check("480i_lines", field_lines, 10'd262);

        // Stop hsync while locked
        tick(8000);
        check("hsstop_hold_fmt", video_format, 8'h02);
        check("hsstop_hold_valid", format_valid, 1'b1);
        tick(300);
        check("hsstop_fmt", video_format, 8'h00);
        check("hsstop_valid", format_valid, 1'b0);
        check("hsstop_changes", fc_count, 5);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
